// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM and condition unit for a 32-bit ARM-subset multicycle datapath.
//   Decodes cond/op/funct/rd from the instruction register. Sequences each
//   instruction through fetch, decode, execute, memory and writeback in 3-5
//   cycles. Holds the NZCV flags and gates every architectural write on the
//   condition check.
//
// Parameters
//   FLAG_RST     reset value of the {N,Z,C,V} flag register
//
// Ports
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous active-low reset
//   cond         in   [3:0] instr[31:28]
//   op           in   [1:0] instr[27:26] (00 data-proc, 01 memory, 10 branch)
//   funct        in   [5:0] instr[25:20] ([5]=I, [4:1]=cmd, [0]=S or L)
//   rd           in   [3:0] instr[15:12]
//   alu_flags    in   [3:0] ALU {N,Z,C,V} of the current operation
//   mem_ready    in   memory handshake (only with CTRL_MEM_WAIT_EN)
//   pc_write, adr_src, mem_write, ir_write, reg_write   out  datapath strobes/selects
//   result_src, alu_src_a, alu_src_b, alu_control       out  datapath selects
//   imm_src, reg_src                                    out  extend / register-port selects
//   flags        out  [3:0] current NZCV register
//   state        out  [3:0] current FSM state encoding
//
// Configuration macro
//   CTRL_MEM_WAIT_EN  adds mem_ready; FETCH, MEMRD and MEMWR stall while it is 0
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
`ifdef CTRL_MEM_WAIT_EN
   input  logic       mem_ready,
`endif
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [3:0] flags,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     cur_state;
   state_t     nxt_state;
   logic [3:0] flag_reg;
   logic [1:0] exec_alu;
   logic       is_cmp;
   logic       cond_ex;
   logic       flag_upd;
   logic       mem_rdy;
   logic       pcw_raw;
   logic       mw_raw;
   logic       irw_raw;
   logic       rw_raw;

   // Standard ARM condition evaluation over {N,Z,C,V}
   function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'b0000: cond_check = z;
         4'b0001: cond_check = ~z;
         4'b0010: cond_check = cf;
         4'b0011: cond_check = ~cf;
         4'b0100: cond_check = n;
         4'b0101: cond_check = ~n;
         4'b0110: cond_check = v;
         4'b0111: cond_check = ~v;
         4'b1000: cond_check = cf & ~z;
         4'b1001: cond_check = ~cf | z;
         4'b1010: cond_check = (n == v);
         4'b1011: cond_check = (n != v);
         4'b1100: cond_check = ~z & (n == v);
         4'b1101: cond_check = z | (n != v);
         4'b1110: cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction

`ifdef CTRL_MEM_WAIT_EN
   assign mem_rdy = mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   assign cond_ex  = cond_check(cond, flag_reg);
   assign is_cmp   = (funct[4:1] == 4'b1010);
   // Flags are sampled at the end of the execute cycle; CMP always sets them.
   assign flag_upd = ((cur_state == EXECR) || (cur_state == EXECI)) &&
                     (funct[0] || is_cmp) && cond_ex;

   // Data-processing command to ALU operation; unknown commands fall back to ADD
   always_comb begin
      exec_alu = 2'b00;
      case (funct[4:1])
         4'b0100: exec_alu = 2'b00;
         4'b0010: exec_alu = 2'b01;
         4'b0000: exec_alu = 2'b10;
         4'b1100: exec_alu = 2'b11;
         4'b1010: exec_alu = 2'b01;
         default: exec_alu = 2'b00;
      endcase
   end

   // State and flag registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_state <= FETCH;
         flag_reg  <= FLAG_RST;
      end else begin
         cur_state <= nxt_state;
         if (flag_upd) begin
            flag_reg[3:2] <= alu_flags[3:2];
            // Logical ops (AND/ORR) leave C and V untouched
            if (!exec_alu[1]) begin
               flag_reg[1:0] <= alu_flags[1:0];
            end
         end
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      nxt_state   = FETCH;
      pcw_raw     = 1'b0;
      mw_raw      = 1'b0;
      irw_raw     = 1'b0;
      rw_raw      = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 2'b00;
      imm_src     = 2'b00;
      reg_src     = 2'b00;
      case (cur_state)
         FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            irw_raw    = mem_rdy;
            pcw_raw    = mem_rdy;
            if (mem_rdy) nxt_state = DECODE;
            else         nxt_state = FETCH;
         end
         DECODE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            reg_src   = 2'b01;
            case (op)
               2'b01:   nxt_state = MEMADR;
               2'b00: begin
                  if (funct[5]) nxt_state = EXECI;
                  else          nxt_state = EXECR;
               end
               2'b10:   nxt_state = BRANCH;
               default: nxt_state = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_b = 2'b01;
            imm_src   = 2'b01;
            if (funct[0]) nxt_state = MEMRD;
            else          nxt_state = MEMWR;
         end
         MEMRD: begin
            adr_src = 1'b1;
            if (mem_rdy) nxt_state = MEMWB;
            else         nxt_state = MEMRD;
         end
         MEMWB: begin
            result_src = 2'b01;
            nxt_state  = FETCH;
            // A load to R15 redirects the PC instead of writing the register file
            if (rd == 4'd15) pcw_raw = cond_ex;
            else             rw_raw  = cond_ex;
         end
         MEMWR: begin
            adr_src = 1'b1;
            reg_src = 2'b10;
            mw_raw  = cond_ex & mem_rdy;
            if (mem_rdy) nxt_state = FETCH;
            else         nxt_state = MEMWR;
         end
         EXECR: begin
            alu_src_b   = 2'b00;
            alu_control = exec_alu;
            nxt_state   = ALUWB;
         end
         EXECI: begin
            alu_src_b   = 2'b01;
            imm_src     = 2'b00;
            alu_control = exec_alu;
            nxt_state   = ALUWB;
         end
         ALUWB: begin
            result_src = 2'b00;
            nxt_state  = FETCH;
            if (rd == 4'd15) pcw_raw = cond_ex & ~is_cmp;
            else             rw_raw  = cond_ex & ~is_cmp;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b01;
            imm_src    = 2'b10;
            result_src = 2'b10;
            pcw_raw    = cond_ex;
            nxt_state  = FETCH;
         end
         default: nxt_state = FETCH;
      endcase
   end

   // While reset is asserted no architectural write may escape
   assign pc_write  = pcw_raw & reset;
   assign mem_write = mw_raw  & reset;
   assign ir_write  = irw_raw & reset;
   assign reg_write = rw_raw  & reset;
   assign flags     = flag_reg;
   assign state     = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. For each instruction the expected
//   per-cycle control record is built from an independent model and queued;
//   records are popped and compared at each negative clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
   logic       alu_src_a;
   logic [3:0] flags, state;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       mw;
      logic       irw;
      logic       rw;
      logic       adr;
      logic [1:0] res;
      logic [1:0] alu;
      logic [3:0] flg;
      logic [2:0] care;   // [2] adr_src, [1] result_src, [0] alu_control
   } rec_t;

   rec_t       sb[$];
   logic [3:0] mflags = 4'b0000;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .alu_flags(alu_flags),
`ifdef CTRL_MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_src(imm_src), .reg_src(reg_src), .flags(flags), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Condition model: even codes test a base predicate, odd codes invert it
   function automatic logic tb_cond(input logic [3:0] c, input logic [3:0] f);
      logic base;
      case (c[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] & ~f[2];
         3'd5: base = (f[3] == f[0]);
         3'd6: base = ~f[2] & (f[3] == f[0]);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? ~base : base;
   endfunction

   function automatic rec_t mk(input logic [3:0] st, input logic pcw, input logic mw,
                               input logic irw, input logic rw, input logic adr,
                               input logic [1:0] res, input logic [1:0] alu,
                               input logic [2:0] care);
      rec_t r;
      r = '{st: st, pcw: pcw, mw: mw, irw: irw, rw: rw, adr: adr,
            res: res, alu: alu, flg: mflags, care: care};
      return r;
   endfunction

   task automatic compare_rec(input rec_t e);
      check_val("state", {28'd0, state}, {28'd0, e.st});
      check_val("pc_write", {31'd0, pc_write}, {31'd0, e.pcw});
      check_val("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
      check_val("ir_write", {31'd0, ir_write}, {31'd0, e.irw});
      check_val("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
      check_val("flags", {28'd0, flags}, {28'd0, e.flg});
      if (e.care[2]) check_val("adr_src", {31'd0, adr_src}, {31'd0, e.adr});
      if (e.care[1]) check_val("result_src", {30'd0, result_src}, {30'd0, e.res});
      if (e.care[0]) check_val("alu_control", {30'd0, alu_control}, {30'd0, e.alu});
   endtask

   // Called at posedge+1 with the FSM in FETCH; returns at posedge+1 in the next FETCH
   task automatic exec_instr(input logic [31:0] ins, input logic [3:0] af, input int stall);
      logic [3:0] c, r, cmd;
      logic [1:0] o, ealu;
      logic [5:0] fn;
      logic       cx, cmp, arith;
      rec_t       e;
      int         k;
      c   = ins[31:28];
      o   = ins[27:26];
      fn  = ins[25:20];
      r   = ins[15:12];
      cmd = fn[4:1];
      cx  = tb_cond(c, mflags);
      cmp = (cmd == 4'b1010);
      arith = (cmd != 4'b0000) && (cmd != 4'b1100);
      case (cmd)
         4'b0010, 4'b1010: ealu = 2'b01;
         4'b0000:          ealu = 2'b10;
         4'b1100:          ealu = 2'b11;
         default:          ealu = 2'b00;
      endcase
      for (int i = 0; i < stall; i++)
         sb.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000));
      sb.push_back(mk(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 3'b111));
      sb.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001));
      case (o)
         2'b00: begin
            sb.push_back(mk(fn[5] ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ealu, 3'b001));
            if (cx && (fn[0] || cmp)) begin
               mflags[3:2] = af[3:2];
               if (arith) mflags[1:0] = af[1:0];
            end
            sb.push_back(mk(4'd8, cx && !cmp && r == 4'd15, 1'b0, 1'b0,
                            cx && !cmp && r != 4'd15, 1'b0, 2'b00, 2'b00, 3'b010));
         end
         2'b01: begin
            sb.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001));
            if (fn[0]) begin
               sb.push_back(mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b100));
               sb.push_back(mk(4'd4, cx && r == 4'd15, 1'b0, 1'b0, cx && r != 4'd15,
                               1'b0, 2'b01, 2'b00, 3'b010));
            end else begin
               sb.push_back(mk(4'd5, 1'b0, cx, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'b100));
            end
         end
         2'b10: sb.push_back(mk(4'd9, cx, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 3'b011));
         default: ;
      endcase
      cond = c; op = o; funct = fn; rd = r; alu_flags = af;
      k = 0;
      while (sb.size() > 0) begin
         mem_ready = (k >= stall);
         @(negedge clk);
         e = sb.pop_front();
         compare_rec(e);
         @(posedge clk);
         #1;
         k++;
      end
      mem_ready = 1'b1;
   endtask

   initial begin
      reset = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0;
      alu_flags = 4'd0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_state", {28'd0, state}, 32'd0);
      check_val("rst_ir_write", {31'd0, ir_write}, 32'd0);
      check_val("rst_pc_write", {31'd0, pc_write}, 32'd0);
      check_val("rst_flags", {28'd0, flags}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      exec_instr(32'hE2821005, 4'b0000, 0);   // ADD R1,R2,#5
      exec_instr(32'hE5910008, 4'b0000, 0);   // LDR R0,[R1,#8]
      exec_instr(32'hE5810004, 4'b0000, 0);   // STR R0,[R1,#4]
      exec_instr(32'hE1500000, 4'b0010, 0);   // CMP -> C=1, Z=0
      exec_instr(32'hE2110000, 4'b0100, 0);   // ANDS result 0 -> Z=1, C kept
      exec_instr(32'h0A000002, 4'b0000, 0);   // BEQ taken
      exec_instr(32'h1A000002, 4'b0000, 0);   // BNE not taken
      exec_instr(32'h12821005, 4'b1111, 0);   // ADDNE with Z=1: no write
      exec_instr(32'hE1500000, 4'b0000, 0);   // CMP -> Z=0
      exec_instr(32'h1A000002, 4'b0000, 0);   // BNE taken
      exec_instr(32'hE28FF004, 4'b0000, 0);   // ADD PC: pc_write, no reg_write
      exec_instr(32'hE591F008, 4'b0000, 0);   // LDR PC
      exec_instr(32'hE2511001, 4'b1001, 0);   // SUBS -> N=1, V=1
      exec_instr(32'hA2821005, 4'b0000, 0);   // ADDGE passes
      exec_instr(32'hB2821005, 4'b0000, 0);   // ADDLT fails
      exec_instr(32'hF2821005, 4'b0000, 0);   // never condition
      exec_instr(32'hEC000000, 4'b0000, 0);   // op=11: back to FETCH
      exec_instr(32'hE3811001, 4'b0000, 0);   // ORR immediate

      // Reset asserted while in MEMADR of a load
      cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd0;
      @(negedge clk); check_val("mid_fetch", {28'd0, state}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check_val("mid_decode", {28'd0, state}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk); check_val("mid_memadr", {28'd0, state}, 32'd2);
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("mid_rst_state", {28'd0, state}, 32'd0);
      check_val("mid_rst_flags", {28'd0, flags}, 32'd0);
      check_val("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
      mflags = 4'b0000;
      reset = 1'b1;
      exec_instr(32'hE5910008, 4'b0000, 0);   // LDR after reset

`ifdef CTRL_MEM_WAIT_EN
      exec_instr(32'hE2821005, 4'b0000, 3);   // FETCH stalled 3 cycles
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
